// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//
// Memory-side responder for the CPU address/datao/data/rw bus. A request is
// accepted while idle, held for WAIT_CYCLES extra cycles, then serviced in a
// single access cycle from on-chip word RAM, from a memory-mapped output
// register, or flagged as out of range. Completion is a one-cycle ready pulse.
//
// Parameters:
//   ADDR_BITS   - word-address width of the RAM (depth 2^ADDR_BITS x 32 bits)
//   WAIT_CYCLES - extra cycles before each access completes (0..15)
//   IO_ADDR     - word address of the output register
//
// Ports:
//   clock   in   1  rising-edge clock
//   reset   in   1  synchronous, active-high reset
//   req     in   1  request valid, sampled only while idle
//   address in  32  word address
//   rw      in   1  1 = read, 0 = write
//   datao   in  32  write data
//   data    out 32  read data, held until the next read completes
//   ready   out  1  one-cycle completion strobe
//   err     out  1  out-of-range flag, meaningful only with ready
//   io_out  out 32  memory-mapped output register

module cpu_mem_responder #(
   parameter int unsigned ADDR_BITS   = 10,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFFC
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] address,
   input  logic        rw,
   input  logic [31:0] datao,
   output logic [31:0] data,
   output logic        ready,
   output logic        err,
   output logic [31:0] io_out
);

   localparam int unsigned Depth = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   state_e                 state_q;
   logic [3:0]             cnt_q;
   logic [31:0]            addr_q;
   logic [31:0]            wdata_q;
   logic                   rw_q;
   logic [31:0]            data_q;
   logic                   ready_q;
   logic                   err_q;
   logic [31:0]            io_q;
   logic [31:0]            mem_q [Depth];

   logic                   hit_io;
   logic                   hit_ram;
   logic                   access;
   logic                   ram_we;
   logic [ADDR_BITS-1:0]   ram_idx;

   // Decode always works on the latched request, never the live bus.
   always_comb begin
      hit_io  = (addr_q == IO_ADDR);
      // The IO register wins if it ever overlaps the RAM window.
      hit_ram = !hit_io && ((addr_q >> ADDR_BITS) == 32'd0);
      ram_idx = addr_q[ADDR_BITS-1:0];
      access  = (state_q == StWait) && (cnt_q == 4'd0);
      // Reset on the access edge must abort the write.
      ram_we  = access && !rw_q && hit_ram && !reset;
   end

   // Controller and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         data_q  <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         io_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               if (req) begin
                  addr_q  <= address;
                  wdata_q <= datao;
                  rw_q    <= rw;
                  cnt_q   <= 4'(WAIT_CYCLES);
                  state_q <= StWait;
               end
            end

            StWait: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  ready_q <= 1'b1;
                  state_q <= StResp;
                  if (hit_io) begin
                     err_q <= 1'b0;
                     if (rw_q) begin
                        data_q <= io_q;
                     end else begin
                        io_q <= wdata_q;
                     end
                  end else if (hit_ram) begin
                     err_q <= 1'b0;
                     // RAM write happens in the storage block below.
                     if (rw_q) begin
                        data_q <= mem_q[ram_idx];
                     end
                  end else begin
                     err_q <= 1'b1;
                     if (rw_q) begin
                        data_q <= '0;
                     end
                  end
               end
            end

            StResp: begin
               // req is deliberately ignored here; the next accept is from idle.
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // RAM storage has no reset; contents survive reset by design.
   always_ff @(posedge clock) begin
      if (ram_we) begin
         mem_q[ram_idx] <= wdata_q;
      end
   end

   assign data   = data_q;
   assign ready  = ready_q;
   assign err    = err_q;
   assign io_out = io_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two instances (WAIT_CYCLES 2 and 0) with a
// timeline-based reference model, directed scenarios and a random phase.

module tb_cpu_mem_responder;

   localparam int          WC0    = 2;
   localparam int          WC1    = 0;
   localparam logic [31:0] IOA    = 32'hFFFF_FFFC;
   localparam int          RDEPTH = 1024;

   logic        clock;
   logic        reset;
   logic        req_s   [2];
   logic [31:0] addr_s  [2];
   logic        rw_s    [2];
   logic [31:0] wd_s    [2];
   logic [31:0] data_s  [2];
   logic        ready_s [2];
   logic        err_s   [2];
   logic [31:0] io_s    [2];

   int vectors;
   int miscompares;
   bit chk_en;

   cpu_mem_responder #(
      .ADDR_BITS  (10),
      .WAIT_CYCLES(WC0),
      .IO_ADDR    (IOA)
   ) u_dut0 (
      .clock  (clock),
      .reset  (reset),
      .req    (req_s[0]),
      .address(addr_s[0]),
      .rw     (rw_s[0]),
      .datao  (wd_s[0]),
      .data   (data_s[0]),
      .ready  (ready_s[0]),
      .err    (err_s[0]),
      .io_out (io_s[0])
   );

   cpu_mem_responder #(
      .ADDR_BITS  (10),
      .WAIT_CYCLES(WC1),
      .IO_ADDR    (IOA)
   ) u_dut1 (
      .clock  (clock),
      .reset  (reset),
      .req    (req_s[1]),
      .address(addr_s[1]),
      .rw     (rw_s[1]),
      .datao  (wd_s[1]),
      .data   (data_s[1]),
      .ready  (ready_s[1]),
      .err    (err_s[1]),
      .io_out (io_s[1])
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- reference model ----------------
   // ph = cycles elapsed since the accept edge, -1 when idle.
   int          ph      [2] = '{-1, -1};
   logic [31:0] l_addr  [2];
   logic [31:0] l_wd    [2];
   logic        l_rw    [2];
   logic        e_rdy   [2];
   logic        e_err   [2];
   logic [31:0] e_data  [2];
   logic [31:0] e_io    [2];
   bit          d_known [2];
   logic [31:0] mmem    [2][RDEPTH];
   bit          mk      [2][RDEPTH];

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         int wc;
         wc = (i == 0) ? WC0 : WC1;
         if (reset) begin
            ph[i]      = -1;
            e_rdy[i]   = 1'b0;
            e_err[i]   = 1'b0;
            e_data[i]  = '0;
            e_io[i]    = '0;
            d_known[i] = 1'b1;
         end else if (ph[i] < 0) begin
            if (req_s[i]) begin
               ph[i]     = 0;
               l_addr[i] = addr_s[i];
               l_wd[i]   = wd_s[i];
               l_rw[i]   = rw_s[i];
            end
         end else begin
            ph[i] = ph[i] + 1;
            if (ph[i] == wc + 1) begin
               e_rdy[i] = 1'b1;
               if (l_addr[i] == IOA) begin
                  e_err[i] = 1'b0;
                  if (l_rw[i]) begin
                     e_data[i]  = e_io[i];
                     d_known[i] = 1'b1;
                  end else begin
                     e_io[i] = l_wd[i];
                  end
               end else if (l_addr[i] < RDEPTH) begin
                  e_err[i] = 1'b0;
                  if (l_rw[i]) begin
                     e_data[i]  = mmem[i][l_addr[i]];
                     d_known[i] = mk[i][l_addr[i]];
                  end else begin
                     mmem[i][l_addr[i]] = l_wd[i];
                     mk[i][l_addr[i]]   = 1'b1;
                  end
               end else begin
                  e_err[i] = 1'b1;
                  if (l_rw[i]) begin
                     e_data[i]  = '0;
                     d_known[i] = 1'b1;
                  end
               end
            end else if (ph[i] == wc + 2) begin
               e_rdy[i] = 1'b0;
               e_err[i] = 1'b0;
               ph[i]    = -1;
            end
         end
      end
   end

   task automatic cmp(input string name, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s inst%0d t=%0t: got %h, expected %h", name, i, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            cmp("ready", i, 32'(ready_s[i]), 32'(e_rdy[i]));
            cmp("err", i, 32'(err_s[i]), 32'(e_err[i]));
            cmp("io_out", i, io_s[i], e_io[i]);
            if (d_known[i]) cmp("data", i, data_s[i], e_data[i]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Issues one request from idle; returns at the negedge where ready is seen.
   // The bus is scrambled while the request is in flight.
   task automatic do_xact(input int i, input logic r, input logic [31:0] a,
                          input logic [31:0] wd, output int lat);
      @(negedge clock);
      req_s[i]  = 1'b1;
      rw_s[i]   = r;
      addr_s[i] = a;
      wd_s[i]   = wd;
      @(posedge clock);
      @(negedge clock);
      req_s[i] = 1'b0;
      lat      = 0;
      while (lat < 40) begin
         addr_s[i] = $urandom;
         wd_s[i]   = $urandom;
         rw_s[i]   = 1'($urandom);
         lat++;
         @(negedge clock);
         if (ready_s[i]) break;
      end
      if (!ready_s[i]) begin
         miscompares++;
         vectors++;
         $display("FAIL timeout inst%0d: ready not seen within %0d cycles", i, lat);
      end
   endtask

   function automatic logic [31:0] pick_addr();
      int k;
      k = $urandom_range(0, 19);
      if (k < 16) return 32'(k);
      else if (k == 16) return IOA;
      else if (k == 17) return 32'h0000_0400;
      else if (k == 18) return 32'hFFFF_FFF8;
      else return $urandom | 32'h8000_0000;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      vectors     = 0;
      miscompares = 0;
      chk_en      = 1'b0;
      reset       = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_s[i]  = 1'b0;
         rw_s[i]   = 1'b0;
         addr_s[i] = '0;
         wd_s[i]   = '0;
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset  = 1'b0;
      chk_en = 1'b1;
      cmp("rst_ready", 0, 32'(ready_s[0]), 32'd0);
      cmp("rst_err", 0, 32'(err_s[0]), 32'd0);
      cmp("rst_data", 0, data_s[0], 32'd0);
      cmp("rst_io", 0, io_s[0], 32'd0);

      // Write/read with scrambled bus during WAIT.
      do_xact(0, 1'b0, 32'd5, 32'hDEAD_BEEF, lat);
      cmp("wr_latency", 0, 32'(lat), 32'd3);
      @(negedge clock);
      cmp("wr_ready_fall", 0, 32'(ready_s[0]), 32'd0);
      do_xact(0, 1'b1, 32'd5, 32'h0, lat);
      cmp("rd_latency", 0, 32'(lat), 32'd3);
      cmp("rd_data5", 0, data_s[0], 32'hDEAD_BEEF);
      cmp("rd_err5", 0, 32'(err_s[0]), 32'd0);
      @(negedge clock);
      cmp("rd_ready_fall", 0, 32'(ready_s[0]), 32'd0);
      cmp("rd_data_hold", 0, data_s[0], 32'hDEAD_BEEF);

      // IO register.
      do_xact(0, 1'b0, IOA, 32'h0000_00A5, lat);
      cmp("io_at_access", 0, io_s[0], 32'h0000_00A5);
      do_xact(0, 1'b1, IOA, 32'h0, lat);
      cmp("io_read", 0, data_s[0], 32'h0000_00A5);

      // Out of range.
      do_xact(0, 1'b0, 32'd0, 32'h1111_0000, lat);
      do_xact(0, 1'b1, 32'h0000_0400, 32'h0, lat);
      cmp("oor_rd_err", 0, 32'(err_s[0]), 32'd1);
      cmp("oor_rd_data", 0, data_s[0], 32'd0);
      @(negedge clock);
      cmp("oor_err_fall", 0, 32'(err_s[0]), 32'd0);
      do_xact(0, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF, lat);
      cmp("oor_wr_err", 0, 32'(err_s[0]), 32'd1);
      do_xact(0, 1'b1, 32'd0, 32'h0, lat);
      cmp("ram0_intact", 0, data_s[0], 32'h1111_0000);

      // Reset on the access edge aborts a write.
      do_xact(0, 1'b0, 32'd7, 32'h0, lat);
      @(negedge clock);
      req_s[0]  = 1'b1;
      rw_s[0]   = 1'b0;
      addr_s[0] = 32'd7;
      wd_s[0]   = 32'h0000_1234;
      @(posedge clock);
      @(negedge clock);
      req_s[0] = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cmp("abort_ready", 0, 32'(ready_s[0]), 32'd0);
      cmp("abort_io", 0, io_s[0], 32'd0);
      @(negedge clock);
      cmp("abort_ready2", 0, 32'(ready_s[0]), 32'd0);
      do_xact(0, 1'b1, 32'd7, 32'h0, lat);
      cmp("abort_ram7", 0, data_s[0], 32'h0);

      // Zero wait states, req held high over four reads.
      for (int n = 0; n < 4; n++) do_xact(1, 1'b0, 32'(n), 32'(n), lat);
      @(negedge clock);
      req_s[1] = 1'b1;
      rw_s[1]  = 1'b1;
      for (int c = 0; c < 12; c++) begin
         addr_s[1] = 32'(c / 3);
         @(posedge clock);
         @(negedge clock);
         cmp("b2b_ready", 1, 32'(ready_s[1]), (c % 3 == 1) ? 32'd1 : 32'd0);
         if (c % 3 == 1) cmp("b2b_data", 1, data_s[1], 32'((c - 1) / 3));
      end
      req_s[1] = 1'b0;
      repeat (4) @(negedge clock);

      // Random traffic on both instances, occasional reset.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++) begin
            req_s[i]  = 1'($urandom);
            rw_s[i]   = 1'($urandom);
            addr_s[i] = pick_addr();
            wd_s[i]   = $urandom;
         end
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) req_s[i] = 1'b0;
      repeat (25) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
